// File: rtl/input_buffer_b5_loader.sv
// Load/read sequencer for the 32-bank B5 input buffer: scatters a word stream round-robin
// across the banks, then serves row reads. Optional zero padding under INPUT_BUFFER_B5_ZERO_PAD_EN.
module input_buffer_b5_loader #(
  parameter int NUM_BANKS  = 32,
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  tile_release,  // consumer finished with tile
  output logic                  buf_full,
  output logic [7:0]            load_words,
  output logic [DATA_WIDTH-1:0] bank_din,
  output logic [ADDR_WIDTH-1:0] bank_addr,
  output logic [NUM_BANKS-1:0]  bank_wea,
  output logic [NUM_BANKS-1:0]  bank_ena,
  output logic                  err_rd
);
  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_FULL = 2'd2;
`ifdef INPUT_BUFFER_B5_ZERO_PAD_EN
  localparam logic [1:0] S_PAD  = 2'd1;
`endif
  localparam logic [7:0]          LAST_IDX = 8'(NUM_BANKS*DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [NUM_BANKS-1:0] ONE     = NUM_BANKS'(1);

  logic [1:0]            state_q, state_d;
  logic [7:0]            count_q, count_d;
  logic                  s_ready_q, s_ready_d;
  logic                  buf_full_q, buf_full_d;
  logic                  err_rd_q, err_rd_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_BANKS-1:0]  wea_q, wea_d, ena_q, ena_d;
`ifdef INPUT_BUFFER_B5_ZERO_PAD_EN
  logic [6:0]            pad_idx_q, pad_idx_d;
`endif
  logic                  hs, rd_legal;

  assign hs       = s_valid & s_ready_q;
  assign rd_legal = rd_en & (state_q == S_FULL) & ({1'b0, rd_addr} < DEPTH_L);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    err_rd_d = err_rd_q | (rd_en & ~rd_legal);
    din_d    = din_q;
    addr_d   = addr_q;
    wea_d    = '0;
    ena_d    = '0;
`ifdef INPUT_BUFFER_B5_ZERO_PAD_EN
    pad_idx_d = pad_idx_q;
`endif
    case (state_q)
      S_LOAD: if (hs) begin
        // word index k -> bank k[4:0], row k[6:5]
        wea_d   = ONE << count_q[4:0];
        ena_d   = ONE << count_q[4:0];
        addr_d  = ADDR_WIDTH'(count_q[6:5]);
        din_d   = s_data;
        count_d = count_q + 8'd1;
        if (count_q == LAST_IDX) state_d = S_FULL;
        else if (s_last) begin
`ifdef INPUT_BUFFER_B5_ZERO_PAD_EN
          state_d   = S_PAD;
          pad_idx_d = count_q[6:0] + 7'd1;
`else
          state_d   = S_FULL;
`endif
        end
      end
`ifdef INPUT_BUFFER_B5_ZERO_PAD_EN
      S_PAD: begin
        wea_d     = ONE << pad_idx_q[4:0];
        ena_d     = ONE << pad_idx_q[4:0];
        addr_d    = ADDR_WIDTH'(pad_idx_q[6:5]);
        din_d     = '0;
        pad_idx_d = pad_idx_q + 7'd1;
        if (pad_idx_q == LAST_IDX[6:0]) state_d = S_FULL;
      end
`endif
      S_FULL: begin
        if (rd_legal) begin
          ena_d  = '1;
          addr_d = rd_addr;
        end
        if (tile_release) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
    s_ready_d  = (state_d == S_LOAD);
    buf_full_d = (state_d == S_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      count_q    <= '0;
      s_ready_q  <= 1'b0;
      buf_full_q <= 1'b0;
      err_rd_q   <= 1'b0;
      din_q      <= '0;
      addr_q     <= '0;
      wea_q      <= '0;
      ena_q      <= '0;
`ifdef INPUT_BUFFER_B5_ZERO_PAD_EN
      pad_idx_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      s_ready_q  <= s_ready_d;
      buf_full_q <= buf_full_d;
      err_rd_q   <= err_rd_d;
      din_q      <= din_d;
      addr_q     <= addr_d;
      wea_q      <= wea_d;
      ena_q      <= ena_d;
`ifdef INPUT_BUFFER_B5_ZERO_PAD_EN
      pad_idx_q  <= pad_idx_d;
`endif
    end
  end

  assign s_ready    = s_ready_q;
  assign buf_full   = buf_full_q;
  assign load_words = count_q;
  assign bank_din   = din_q;
  assign bank_addr  = addr_q;
  assign bank_wea   = wea_q;
  assign bank_ena   = ena_q;
  assign err_rd     = err_rd_q;
endmodule

// File: tb/tb_input_buffer_b5_loader.sv
// Directed bench for input_buffer_b5_loader; expectations follow the macro setting of the build.
module tb_input_buffer_b5_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic        rd_en, tile_release, buf_full, err_rd;
  logic [2:0]  rd_addr, bank_addr;
  logic [7:0]  load_words;
  logic [31:0] bank_din, bank_wea, bank_ena;
  int checks = 0;
  int failures = 0;

  input_buffer_b5_loader dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .rd_en(rd_en), .rd_addr(rd_addr), .tile_release(tile_release),
    .buf_full(buf_full), .load_words(load_words), .bank_din(bank_din),
    .bank_addr(bank_addr), .bank_wea(bank_wea), .bank_ena(bank_ena), .err_rd(err_rd)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wea"}, bank_wea, 32'h0);
    chk({tag, "_ena"}, bank_ena, 32'h0);
  endtask

  // one accepted beat; write strobes must land on word index idx next cycle
  task automatic beat(input logic [31:0] d, input logic l, input int idx);
    s_data = d; s_valid = 1'b1; s_last = l;
    tick;
    chk("wr_wea", bank_wea, 32'h1 << idx[4:0]);
    chk("wr_ena", bank_ena, 32'h1 << idx[4:0]);
    chk("wr_addr", {29'b0, bank_addr}, 32'(idx[6:5]));
    chk("wr_din", bank_din, d);
    chk("wr_lw", {24'b0, load_words}, 32'(idx + 1));
  endtask

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    rd_en = 1'b0; rd_addr = '0; tile_release = 1'b0;
    tick; tick;
    chk("rst_s_ready", {31'b0, s_ready}, 32'h0);
    chk("rst_buf_full", {31'b0, buf_full}, 32'h0);
    chk("rst_lw", {24'b0, load_words}, 32'h0);
    chk("rst_din", bank_din, 32'h0);
    chk("rst_addr", {29'b0, bank_addr}, 32'h0);
    chk_idle("rst");
    chk("rst_err", {31'b0, err_rd}, 32'h0);
    rst = 1'b0;
    tick;
    chk("post_rst_s_ready", {31'b0, s_ready}, 32'h1);

    // read during LOAD is illegal
    rd_en = 1'b1; rd_addr = 3'd0;
    tick;
    rd_en = 1'b0;
    chk_idle("rd_load");
    chk("rd_load_err", {31'b0, err_rd}, 32'h1);
    chk("rd_load_lw", {24'b0, load_words}, 32'h0);

    // partial tile then reset mid-load
    for (int k = 0; k < 70; k++) beat(32'hC000_0000 + 32'(k), 1'b0, k);
    rst = 1'b1;
    tick;
    s_valid = 1'b0;
    chk("mid_rst_s_ready", {31'b0, s_ready}, 32'h0);
    chk("mid_rst_lw", {24'b0, load_words}, 32'h0);
    chk("mid_rst_err", {31'b0, err_rd}, 32'h0);
    chk("mid_rst_din", bank_din, 32'h0);
    chk_idle("mid_rst");
    rst = 1'b0;
    tick;
    chk("mid_rst_ready", {31'b0, s_ready}, 32'h1);

    // full 128-word tile, continuous valid
    for (int k = 0; k < 128; k++) begin
      beat(32'(k), 1'b0, k);
      chk("full_bf", {31'b0, buf_full}, (k == 127) ? 32'h1 : 32'h0);
      chk("full_rdy", {31'b0, s_ready}, (k == 127) ? 32'h0 : 32'h1);
    end
    s_data = 32'hDEAD_BEEF;
    tick;
    s_valid = 1'b0;
    chk_idle("stall");
    chk("stall_lw", {24'b0, load_words}, 32'd128);

    // legal row read
    rd_en = 1'b1; rd_addr = 3'd2;
    tick;
    rd_en = 1'b0;
    chk("rd_ena", bank_ena, 32'hFFFF_FFFF);
    chk("rd_wea", bank_wea, 32'h0);
    chk("rd_addr", {29'b0, bank_addr}, 32'd2);
    chk("rd_err", {31'b0, err_rd}, 32'h0);
    tick;
    chk_idle("rd_after");

    // out-of-range row
    rd_en = 1'b1; rd_addr = 3'd5;
    tick;
    rd_en = 1'b0;
    chk_idle("rd_oob");
    chk("rd_oob_err", {31'b0, err_rd}, 32'h1);

    // read and release together
    rd_en = 1'b1; rd_addr = 3'd1; tile_release = 1'b1;
    tick;
    rd_en = 1'b0; tile_release = 1'b0;
    chk("rr_ena", bank_ena, 32'hFFFF_FFFF);
    chk("rr_addr", {29'b0, bank_addr}, 32'd1);
    chk("rr_bf", {31'b0, buf_full}, 32'h0);
    chk("rr_rdy", {31'b0, s_ready}, 32'h1);
    chk("rr_lw", {24'b0, load_words}, 32'h0);

    // short tile: 40 words, s_last on word 39
    for (int k = 0; k < 40; k++) beat(32'hA000 + 32'(k), k == 39, k);
    s_valid = 1'b0; s_last = 1'b0;
    chk("short_rdy", {31'b0, s_ready}, 32'h0);
`ifdef INPUT_BUFFER_B5_ZERO_PAD_EN
    chk("short_bf", {31'b0, buf_full}, 32'h0);
    for (int i = 0; i < 88; i++) begin
      tick;
      chk("pad_wea", bank_wea, 32'h1 << ((40 + i) % 32));
      chk("pad_addr", {29'b0, bank_addr}, 32'((40 + i) / 32));
      chk("pad_din", bank_din, 32'h0);
      chk("pad_bf", {31'b0, buf_full}, (i == 87) ? 32'h1 : 32'h0);
    end
    tick;
    chk_idle("pad_done");
`else
    chk("short_bf", {31'b0, buf_full}, 32'h1);
    tick;
    chk_idle("short_done");
`endif
    chk("short_lw", {24'b0, load_words}, 32'd40);

    tile_release = 1'b1;
    tick;
    tile_release = 1'b0;
    chk("rel_bf", {31'b0, buf_full}, 32'h0);
    chk("rel_err_sticky", {31'b0, err_rd}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
